// File: rtl/conv_pkg.sv
// conv_pkg: dimensions, widths and scheduler state type for the first conv layer.
package conv_pkg;
  localparam int DATA_X = 28;
  localparam int DATA_Y = 28;
  localparam int WEIGHT_X = 5;
  localparam int WEIGHT_Y = 5;
  localparam int NUM_KERNELS = 8;
  localparam int DATA_SIZE = 32;
  localparam int WEIGHT_SIZE = 32;
  localparam int CONV_SIZE = 69;
  function automatic int conv_dim(input int d, input int w);
    return d - w + 1;
  endfunction
  localparam int CONV_X = conv_dim(DATA_X, WEIGHT_X);
  localparam int CONV_Y = conv_dim(DATA_Y, WEIGHT_Y);
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUTPUT, DONE} conv_sched_state_t;
endpackage

// File: rtl/conv_scheduler_if.sv
// conv_scheduler_if: buffer read bus and result stream between scheduler and its neighbours.
interface conv_scheduler_if #(
  parameter int DX = conv_pkg::DATA_X,
  parameter int DY = conv_pkg::DATA_Y,
  parameter int NK = conv_pkg::NUM_KERNELS
);
  import conv_pkg::*;
  localparam int KW = $clog2(NK);
  localparam int RW = $clog2(DX);
  localparam int CW = $clog2(DY);
  localparam int XW = $clog2(conv_dim(DX, WEIGHT_X));
  localparam int YW = $clog2(conv_dim(DY, WEIGHT_Y));
  localparam int IW = $clog2(WEIGHT_X);
  localparam int JW = $clog2(WEIGHT_Y);
  logic data_rd_en;
  logic [RW-1:0] data_rd_row;
  logic [CW-1:0] data_rd_col;
  logic signed [DATA_SIZE-1:0] data_rd_val;
  logic [KW-1:0] w_rd_kernel;
  logic [IW-1:0] w_rd_row;
  logic [JW-1:0] w_rd_col;
  logic signed [WEIGHT_SIZE-1:0] w_rd_val;
  logic res_valid;
  logic res_ready;
  logic [KW-1:0] res_kernel;
  logic [XW-1:0] res_x;
  logic [YW-1:0] res_y;
  logic signed [CONV_SIZE-1:0] res_data;
  modport master (
    output data_rd_en, data_rd_row, data_rd_col, w_rd_kernel, w_rd_row, w_rd_col,
    output res_valid, res_kernel, res_x, res_y, res_data,
    input data_rd_val, w_rd_val, res_ready
  );
  modport slave (
    input data_rd_en, data_rd_row, data_rd_col, w_rd_kernel, w_rd_row, w_rd_col,
    input res_valid, res_kernel, res_x, res_y, res_data,
    output data_rd_val, w_rd_val, res_ready
  );
endinterface

// File: rtl/conv_mac.sv
// conv_mac: single signed multiply-accumulate; load replaces the sum with the first product of a window.
module conv_mac import conv_pkg::*; (
  input logic clk,
  input logic rst,
  input logic load,
  input logic acc_en,
  input logic signed [DATA_SIZE-1:0] a,
  input logic signed [WEIGHT_SIZE-1:0] b,
  output logic signed [CONV_SIZE-1:0] sum
);
  localparam int PW = DATA_SIZE + WEIGHT_SIZE;
  logic signed [PW-1:0] p;
  logic signed [CONV_SIZE-1:0] p_ext;
  assign p = a * b;
  assign p_ext = {{(CONV_SIZE-PW){p[PW-1]}}, p};
  always_ff @(posedge clk or posedge rst)
    if (rst) sum <= '0;
    else if (acc_en) sum <= load ? p_ext : sum + p_ext;
endmodule

// File: rtl/conv_scheduler.sv
// conv_scheduler: walks k,x,y,i,j issuing one read pair per cycle into a single MAC,
// then streams each finished window over a valid/ready handshake.
module conv_scheduler #(
  parameter int DX = conv_pkg::DATA_X,
  parameter int DY = conv_pkg::DATA_Y,
  parameter int NK = conv_pkg::NUM_KERNELS
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic abort,
  output logic busy,
  output logic done,
  conv_scheduler_if.master bus
);
  import conv_pkg::*;
  localparam int KW = $clog2(NK);
  localparam int RW = $clog2(DX);
  localparam int CW = $clog2(DY);
  localparam int XW = $clog2(conv_dim(DX, WEIGHT_X));
  localparam int YW = $clog2(conv_dim(DY, WEIGHT_Y));
  localparam int IW = $clog2(WEIGHT_X);
  localparam int JW = $clog2(WEIGHT_Y);
  localparam logic [KW-1:0] K_LAST = KW'(NK - 1);
  localparam logic [XW-1:0] X_LAST = XW'(conv_dim(DX, WEIGHT_X) - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(conv_dim(DY, WEIGHT_Y) - 1);
  localparam logic [IW-1:0] I_LAST = IW'(WEIGHT_X - 1);
  localparam logic [JW-1:0] J_LAST = JW'(WEIGHT_Y - 1);
  conv_sched_state_t state, state_n;
  logic [KW-1:0] k;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic rd_d, first_d;
  logic last_k, last_x, last_y, last_i, last_j, handshake;
  assign last_k = k == K_LAST;
  assign last_x = x == X_LAST;
  assign last_y = y == Y_LAST;
  assign last_i = i == I_LAST;
  assign last_j = j == J_LAST;
  assign handshake = bus.res_valid && bus.res_ready;
  always_comb begin
    busy = state != IDLE;
    done = state == DONE && !abort;
    bus.data_rd_en = state == FETCH && !abort;
    bus.res_valid = state == OUTPUT && !abort;
    state_n = abort ? IDLE :
              state == IDLE ? (start ? FETCH : IDLE) :
              state == FETCH ? (last_i && last_j ? DRAIN : FETCH) :
              state == DRAIN ? OUTPUT :
              state == OUTPUT ? (!bus.res_ready ? OUTPUT : last_y && last_x && last_k ? DONE : FETCH) :
              IDLE;
  end
  assign bus.data_rd_row = RW'(x) + RW'(i);
  assign bus.data_rd_col = CW'(y) + CW'(j);
  assign bus.w_rd_kernel = k;
  assign bus.w_rd_row = i;
  assign bus.w_rd_col = j;
  assign bus.res_kernel = k;
  assign bus.res_x = x;
  assign bus.res_y = y;
  // i,j wrap to zero on the last tap, so every FETCH entry starts at tap (0,0)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      {k, x, y, i, j} <= '0;
      rd_d <= 1'b0;
      first_d <= 1'b0;
    end else begin
      state <= state_n;
      rd_d <= bus.data_rd_en;
      first_d <= i == '0 && j == '0;
      if (state == IDLE) {k, x, y, i, j} <= '0;
      else if (bus.data_rd_en) begin
        j <= last_j ? '0 : j + 1'b1;
        if (last_j) i <= last_i ? '0 : i + 1'b1;
      end else if (handshake) begin
        y <= last_y ? '0 : y + 1'b1;
        if (last_y) x <= last_x ? '0 : x + 1'b1;
        if (last_y && last_x) k <= last_k ? '0 : k + 1'b1;
      end
    end
  conv_mac u_mac (
    .clk(clk),
    .rst(rst),
    .load(first_d),
    .acc_en(rd_d && !abort),
    .a(bus.data_rd_val),
    .b(bus.w_rd_val),
    .sum(bus.res_data)
  );
endmodule

// File: tb/tb_conv_scheduler.sv
// tb_conv_scheduler: directed checks of the conv scheduler on a reduced 8x8 image, 2-kernel layer.
module tb_conv_scheduler;
  localparam int DX = 8;
  localparam int DY = 8;
  localparam int NK = 2;
  localparam int NRES = NK * 16;
  logic clk = 1'b0;
  logic rst, start, abort, busy, done;
  int n_chk = 0;
  int n_fail = 0;
  int unsigned cycle = 0;
  logic signed [31:0] pix [DX][DY];
  logic signed [31:0] wt [NK][5][5];
  logic signed [68:0] first_data;
  conv_scheduler_if #(.DX(DX), .DY(DY), .NK(NK)) bus ();
  conv_scheduler #(.DX(DX), .DY(DY), .NK(NK)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;
  always @(posedge clk)
    if (bus.data_rd_en) begin
      bus.data_rd_val <= pix[bus.data_rd_row][bus.data_rd_col];
      bus.w_rd_val <= wt[bus.w_rd_kernel][bus.w_rd_row][bus.w_rd_col];
    end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [68:0] got, input logic [68:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic signed [68:0] gold(input int k, input int x, input int y);
    logic signed [68:0] s;
    logic signed [63:0] p;
    s = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        p = pix[x+i][y+j] * wt[k][i][j];
        s = s + {{5{p[63]}}, p};
      end
    return s;
  endfunction
  task automatic run_pass(input bit poke);
    int idx, dones, first_lat, done_lat;
    int unsigned c0;
    bit fin;
    idx = 0; dones = 0; first_lat = -1; done_lat = -1; fin = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cycle;
    for (int t = 0; t < 1200 && !fin; t++) begin
      if (bus.res_valid) begin
        if (first_lat < 0) begin
          first_lat = int'(cycle - c0);
          first_data = bus.res_data;
        end
        chk("res_kernel", bus.res_kernel, idx / 16);
        chk("res_x", bus.res_x, idx / 4 % 4);
        chk("res_y", bus.res_y, idx % 4);
        chk("res_data", bus.res_data, gold(idx / 16, idx / 4 % 4, idx % 4));
        idx++;
      end
      if (done) begin
        dones++;
        done_lat = int'(cycle - c0);
        fin = 1;
      end
      start = poke && !fin && (t % 37 == 5);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (3) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("result_count", idx, NRES);
    chk("first_valid_latency", first_lat, 26);
    chk("done_latency", done_lat, NRES * 27);
    chk("done_pulses", dones, 1);
    chk("idle_after_pass", busy, 0);
  endtask
  initial begin
    int w, cnt;
    bit seen;
    rst = 1'b1; start = 1'b0; abort = 1'b0; bus.res_ready = 1'b1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_rd_en", bus.data_rd_en, 0);
    chk("rst_data", bus.res_data, 0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", busy, 0);
    // all-ones image, kernel0 all ones, kernel1 zero
    for (int r = 0; r < DX; r++) for (int c = 0; c < DY; c++) pix[r][c] = 1;
    for (int k = 0; k < NK; k++) for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) wt[k][i][j] = (k == 0) ? 1 : 0;
    run_pass(0);
    chk("t1_k0_00", first_data, 69'sd25);
    // single extreme tap
    for (int r = 0; r < DX; r++) for (int c = 0; c < DY; c++) pix[r][c] = 0;
    for (int k = 0; k < NK; k++) for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) wt[k][i][j] = 0;
    pix[0][0] = -3;
    wt[0][0][0] = 32'sh8000_0000;
    run_pass(0);
    chk("t2_k0_00", first_data, 69'sd6442450944);
    // backpressure on the first result
    for (int r = 0; r < DX; r++) for (int c = 0; c < DY; c++) pix[r][c] = $urandom;
    for (int k = 0; k < NK; k++) for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) wt[k][i][j] = $urandom;
    bus.res_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!bus.res_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("t3_reach_output", bus.res_valid, 1);
    for (int c = 0; c < 10; c++) begin
      chk("t3_hold_data", bus.res_data, gold(0, 0, 0));
      chk("t3_no_read", bus.data_rd_en, 0);
      @(negedge clk);
    end
    chk("t3_hold_xy", {bus.res_kernel, bus.res_x, bus.res_y}, 0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("t3_refetch", bus.data_rd_en, 1);
    chk("t3_valid_low", bus.res_valid, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t3_abort_idle", busy, 0);
    // abort on the 12th FETCH cycle
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    abort = 1'b1;
    #1;
    chk("t4_rd_drop", bus.data_rd_en, 0);
    chk("t4_busy_during", busy, 1);
    @(negedge clk);
    abort = 1'b0;
    chk("t4_busy_after", busy, 0);
    seen = 0;
    repeat (40) begin
      if (bus.res_valid || done || busy) seen = 1;
      @(negedge clk);
    end
    chk("t4_quiet", seen, 0);
    run_pass(1);
    // async reset while stalled in OUTPUT mid-pass
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0; w = 0; seen = 0;
    while (!seen && w < 400) begin
      if (bus.res_valid) begin
        if (cnt == 5) seen = 1;
        else cnt++;
      end
      if (!seen) begin
        @(negedge clk);
        w++;
      end
    end
    bus.res_ready = 1'b0;
    chk("t5_pre_xy", {bus.res_x, bus.res_y}, 4'b0101);
    #3 rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_valid", bus.res_valid, 0);
    chk("t5_data", bus.res_data, 0);
    chk("t5_xy", {bus.res_kernel, bus.res_x, bus.res_y}, 0);
    chk("t5_rd", {bus.data_rd_en, bus.data_rd_row, bus.data_rd_col}, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.res_ready = 1'b1;
    chk("t5_idle", busy, 0);
    run_pass(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
